// File: rtl/posit_round_sum_es2_pkg.sv
// Shared types and constants for the ES2 posit rounding/re-packing stage.
package posit_round_sum_es2_pkg;

  localparam int ABITS                          = 30;  // adder sum fraction width
  localparam int FBITS                          = 27;  // operand fraction width
  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES2 = 41;
  localparam int POSIT_SERIALIZED_WIDTH_ES2     = 38;
  localparam int POSIT_MAX_SCALE_ES2            = 120; // (32-2)*4
  localparam int LATENCY                        = 3;   // start -> done, fixed

  // Serialized adder sum: {sgn, scale, fraction, inf, zero}
  typedef struct packed {
    logic              sgn;
    logic signed [7:0] scale;
    logic [ABITS-1:0]  fraction;
    logic              inf;
    logic              zero;
  } value_sum_t;

  // Serialized operand-width value: {sgn, scale, fraction, inf, zero}
  typedef struct packed {
    logic              sgn;
    logic signed [7:0] scale;
    logic [FBITS-1:0]  fraction;
    logic              inf;
    logic              zero;
  } value_t;

  // Bits that decide round-to-nearest-even
  typedef struct packed {
    logic lsb;
    logic guard;
    logic round;
    logic sticky;
  } round_bits_t;

endpackage

// File: rtl/posit_round_sum_es2_round.sv
// Combinational round-to-nearest-even of an (N+3)-bit fraction down to N bits.
// The three dropped bits are guard, round and sticky; sticky_in folds in
// information already lost upstream.
module round_rne_n
  import posit_round_sum_es2_pkg::*;
#(
  parameter int N = 27
) (
  input  logic [N+2:0] fraction,
  input  logic         sticky_in,
  output logic [N-1:0] rounded,
  output logic         carry,
  output logic         inexact
);

  round_bits_t rb;
  logic        round_up;

  // Extract the decision bits and add the rounding increment
  always_comb begin
    rb.lsb    = fraction[3];
    rb.guard  = fraction[2];
    rb.round  = fraction[1];
    rb.sticky = fraction[0] | sticky_in;
    // Ties (G=1, R=S=0) go to the even neighbour: increment only when lsb is 1.
    round_up  = rb.guard & (rb.round | rb.sticky | rb.lsb);
    inexact   = rb.guard | rb.round | rb.sticky;
    {carry, rounded} = {1'b0, fraction[N+2:3]} + {{N{1'b0}}, round_up};
  end

endmodule

// File: rtl/posit_round_sum_es2.sv
// Three-stage pipeline: capture adder sum, round to operand width (RNE),
// renormalize on carry, clamp scale and handle inf/zero.
module posit_round_sum_es2
  import posit_round_sum_es2_pkg::*;
#(
  parameter int MAX_SCALE = POSIT_MAX_SCALE_ES2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0] in1,
  input  logic                                      truncated_in,
  input  logic                                      start,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]     result,
  output logic                                      done,
  output logic                                      inexact
);

  localparam logic signed [8:0] SCALE_HI = 9'(MAX_SCALE);
  localparam logic signed [8:0] SCALE_LO = -SCALE_HI;

  // S0 stage
  logic       s0_valid;
  value_sum_t s0_in;
  logic       s0_trunc;

  // Rounder outputs (between S0 and S1)
  logic [FBITS-1:0] rnd_frac;
  logic             rnd_carry;
  logic             rnd_inexact;

  // S1 stage
  logic              s1_valid;
  logic              s1_sgn;
  logic signed [7:0] s1_scale;
  logic [FBITS-1:0]  s1_frac;
  logic              s1_carry;
  logic              s1_inexact;
  logic              s1_inf;
  logic              s1_zero;

  // S2 next-state and registers
  logic signed [8:0] scale_ext;
  value_t            res_nx;
  logic              inx_nx;
  value_t            result_q;

  // S0 valid: reset wins over start
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous stage's value from before this edge.
    if (!rst_n) s0_valid <= 1'b0;
    // NOTE: case-equality maps an X/Z on start to "not valid".
    else        s0_valid <= (start === 1'b1);
  end

  // S0 data capture
  always_ff @(posedge clk) begin
    // NOTE: data registers carry no reset; their valid bit qualifies them.
    s0_in    <= value_sum_t'(in1);
    s0_trunc <= truncated_in;
  end

  round_rne_n #(.N(FBITS)) u_round (
    .fraction  (s0_in.fraction),
    .sticky_in (s0_trunc),
    .rounded   (rnd_frac),
    .carry     (rnd_carry),
    .inexact   (rnd_inexact)
  );

  // S1 valid
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= s0_valid;
  end

  // S1 data: rounded fraction plus the fields that pass through
  always_ff @(posedge clk) begin
    s1_sgn     <= s0_in.sgn;
    s1_scale   <= s0_in.scale;
    s1_frac    <= rnd_frac;
    s1_carry   <= rnd_carry;
    s1_inexact <= rnd_inexact;
    s1_inf     <= s0_in.inf;
    s1_zero    <= s0_in.zero;
  end

  // S2 combinational: renormalize, clamp scale, apply special values
  always_comb begin
    // NOTE: defaults first so every path assigns every bit (no latches).
    res_nx    = '0;
    inx_nx    = 1'b0;
    scale_ext = $signed({s1_scale[7], s1_scale}) + $signed({8'd0, s1_carry});
    if (s1_inf) begin
      res_nx.inf = 1'b1;
    end else if (s1_zero) begin
      res_nx.zero = 1'b1;
    end else begin
      res_nx.sgn      = s1_sgn;
      inx_nx          = s1_inexact;
      // On carry the hidden bit moved up one position and the fraction is zero.
      res_nx.fraction = s1_carry ? '0 : s1_frac;
      res_nx.scale    = scale_ext[7:0];
      if (scale_ext > SCALE_HI) begin
        res_nx.scale    = SCALE_HI[7:0];
        res_nx.fraction = '0;
      end else if (scale_ext < SCALE_LO) begin
        // Posits saturate toward minpos instead of underflowing to zero.
        res_nx.scale    = SCALE_LO[7:0];
        res_nx.fraction = '0;
      end
    end
  end

  // S2 output registers: held while no valid item arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done     <= 1'b0;
      result_q <= '0;
      inexact  <= 1'b0;
    end else begin
      done <= s1_valid;
      if (s1_valid) begin
        result_q <= res_nx;
        inexact  <= inx_nx;
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_posit_round_sum_es2.sv
// Self-checking bench for posit_round_sum_es2: directed rounding/clamping
// cases, reset behaviour and randomized streams against a numeric model.
module tb_posit_round_sum_es2;
  import posit_round_sum_es2_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [40:0] in1;
  logic        truncated_in;
  logic        start;
  logic [37:0] result;
  logic        done;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  posit_round_sum_es2 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in1          (in1),
    .truncated_in (truncated_in),
    .start        (start),
    .result       (result),
    .done         (done),
    .inexact      (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [40:0] mk(input logic s, input logic [7:0] sc,
                                     input logic [29:0] f, input logic inf,
                                     input logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [37:0] ex(input logic s, input logic [7:0] sc,
                                     input logic [26:0] f);
    return {s, sc, f, 2'b00};
  endfunction

  // Reference: round the value (fraction / 8) to nearest integer, ties to even,
  // with the adder's truncation meaning "strictly above what the bits show".
  function automatic logic [38:0] model(input logic [40:0] v, input logic tr);
    longint q;
    int     rem;
    int     sc;
    bit     up;
    bit     inx;
    if (v[1]) return {1'b0, 8'd0, 27'd0, 1'b1, 1'b0, 1'b0};
    if (v[0]) return {38'd1, 1'b0};
    sc  = int'($signed(v[39:32]));
    q   = longint'(v[31:2]) / 8;
    rem = int'(longint'(v[31:2]) % 8);
    if (rem > 4)       up = 1'b1;
    else if (rem == 4) up = tr || (q % 2 == 1);
    else               up = 1'b0;
    inx = (rem != 0) || tr;
    q   = q + (up ? 1 : 0);
    if (q == (longint'(1) << 27)) begin
      q  = 0;
      sc = sc + 1;
    end
    if (sc > 120) begin
      sc = 120;
      q  = 0;
    end else if (sc < -120) begin
      sc = -120;
      q  = 0;
    end
    return {v[40], 8'(sc), 27'(q), 2'b00, inx};
  endfunction

  function automatic logic [40:0] rand_value();
    logic [29:0] f;
    logic [7:0]  sc;
    f  = 30'($urandom);
    sc = 8'($urandom);
    if ($urandom_range(0, 3) == 0) f[29:3] = '1;
    if ($urandom_range(0, 3) == 0) sc = 8'(117 + $urandom_range(0, 6));
    else if ($urandom_range(0, 5) == 0) sc = 8'(-123 + int'($urandom_range(0, 6)));
    return mk(1'($urandom), sc, f, ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b expected 0", done);
    end
    checks++;
    if (result !== 38'd0) begin
      errors++;
      $display("FAIL reset_result got %h expected 0", result);
    end
    checks++;
    if (inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset_inexact got %b expected 0", inexact);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [40:0] v;
    logic        tr;
    logic [37:0] exp_res;
    logic        exp_inx;
  } dcase_t;

  task automatic test_directed();
    dcase_t tc[10];
    tc[0] = '{"exact",      mk(0, 8'd5,   30'h2AAAAAA8, 0, 0), 0, ex(0, 8'd5, 27'h5555555),   0};
    tc[1] = '{"tie_even",   mk(0, 8'd5,   30'h2AAAAAA4, 0, 0), 0, ex(0, 8'd5, 27'h5555554),   1};
    tc[2] = '{"tie_odd",    mk(0, 8'd5,   30'h2AAAAAAC, 0, 0), 0, ex(0, 8'd5, 27'h5555556),   1};
    tc[3] = '{"sticky",     mk(1, 8'd5,   30'h2AAAAAA4, 0, 0), 1, ex(1, 8'd5, 27'h5555555),   1};
    tc[4] = '{"carry",      mk(0, 8'd5,   30'h3FFFFFFE, 0, 0), 0, ex(0, 8'd6, 27'd0),         1};
    tc[5] = '{"clamp_hi",   mk(0, 8'd120, 30'h3FFFFFFF, 0, 0), 0, ex(0, 8'd120, 27'd0),       1};
    tc[6] = '{"clamp_lo",   mk(1, 8'h80,  30'h12345678, 0, 0), 0, ex(1, 8'h88, 27'd0),        0};
    tc[7] = '{"carry_edge", mk(0, 8'd119, 30'h3FFFFFFF, 0, 0), 0, ex(0, 8'd120, 27'd0),       1};
    tc[8] = '{"zero",       mk(1, 8'd7,   30'h0000000F, 0, 1), 1, 38'd1,                      0};
    tc[9] = '{"inf_zero",   mk(1, 8'd7,   30'h3FFFFFFF, 1, 1), 1, 38'b10,                     0};
    foreach (tc[i]) begin
      @(negedge clk);
      in1          = tc[i].v;
      truncated_in = tc[i].tr;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      in1          = rand_value();
      truncated_in = 1'($urandom);
      repeat (LATENCY - 1) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s early_done got %b expected 0", tc[i].name, done);
        end
        @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s done got %b expected 1", tc[i].name, done);
      end
      checks++;
      if (result !== tc[i].exp_res) begin
        errors++;
        $display("FAIL %s result got %h expected %h", tc[i].name, result, tc[i].exp_res);
      end
      checks++;
      if (inexact !== tc[i].exp_inx) begin
        errors++;
        $display("FAIL %s inexact got %b expected %b", tc[i].name, inexact, tc[i].exp_inx);
      end
    end
  endtask

  // Streams n items (optionally with idle gaps) and checks order and values.
  task automatic test_stream(input int n, input bit gaps, input string tag);
    logic [38:0] q[$];
    int          got = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
              @(negedge clk);
              start = 1'b0;
            end
          end
          @(negedge clk);
          in1          = rand_value();
          truncated_in = 1'($urandom);
          start        = 1'b1;
          q.push_back(model(in1, truncated_in));
        end
        @(negedge clk);
        start = 1'b0;
      end
      begin
        logic [38:0] exp_v;
        while (got < n && cyc < n * 4 + 20) begin
          @(negedge clk);
          cyc++;
          if (done === 1'b1) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL %s spurious_done got done=1 expected no pending item", tag);
            end else begin
              exp_v = q.pop_front();
              if ({result, inexact} !== exp_v) begin
                errors++;
                $display("FAIL %s item%0d got %h/%b expected %h/%b", tag, got,
                         result, inexact, exp_v[38:1], exp_v[0]);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s count got %0d expected %0d", tag, got, n);
    end
    if (!gaps) begin
      checks++;
      if (last_cyc - first_cyc != n - 1) begin
        errors++;
        $display("FAIL %s consecutive got span %0d expected %0d", tag,
                 last_cyc - first_cyc, n - 1);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [38:0] exp_v;
    // Two starts, then reset: neither may emerge.
    @(negedge clk);
    in1 = rand_value(); truncated_in = 1'($urandom); start = 1'b1;
    @(negedge clk);
    in1 = rand_value(); truncated_in = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (result !== 38'd0 || inexact !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear got %h/%b expected 0/0", result, inexact);
    end
    repeat (6) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_drop got done=%b expected 0", done);
      end
      @(negedge clk);
    end
    // Start coincident with reset is discarded.
    rst_n = 1'b0;
    in1 = rand_value(); start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (5) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_start_discard got done=%b expected 0", done);
      end
      @(negedge clk);
    end
    // First start after release completes with normal latency.
    in1 = mk(0, 8'd5, 30'h2AAAAAAC, 0, 0); truncated_in = 1'b0; start = 1'b1;
    exp_v = model(in1, truncated_in);
    @(negedge clk);
    start = 1'b0;
    repeat (LATENCY - 1) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_early got done=%b expected 0", done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || {result, inexact} !== exp_v) begin
      errors++;
      $display("FAIL post_reset_item got %b %h/%b expected 1 %h/%b", done, result,
               inexact, exp_v[38:1], exp_v[0]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    in1          = '0;
    truncated_in = 1'b0;
    test_reset();
    test_directed();
    test_stream(5, 1'b0, "back_to_back");
    test_reset_mid();
    test_stream(300, 1'b1, "random_gaps");
    test_stream(100, 1'b0, "random_b2b");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
